// File: rtl/onehot_sweep_decoder.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder with a valid/ready command port.
// DIRECT decodes in one cycle; SWEEP walks the hot bit from 0 to the target with DWELL cycles per step.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | ready for a command; out/out_valid hold the last result
// SWEEP | stepping the hot bit toward the latched target
module onehot_sweep_decoder #(
  parameter int SEL_W = 3,
  parameter int DWELL = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic                  in_mode,
  input  logic                  clr,
  output logic [2**SEL_W-1:0]   out,
  output logic                  out_valid,
  output logic                  busy,
  output logic                  done
);

  localparam int OUT_W = 2**SEL_W;
  localparam int CNT_W = $clog2(DWELL + 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [SEL_W-1:0]    index;
  logic [SEL_W-1:0]    index_nx;
  logic [SEL_W-1:0]    target;
  logic [SEL_W-1:0]    target_nx;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_nx;
  logic [OUT_W-1:0]    out_nx;
  logic                out_valid_nx;
  logic                done_nx;
  logic                accept;
  logic                dwell_running;
  logic                at_target;

  function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] code);
    logic [OUT_W-1:0] vec;
    vec = '0;
    vec[code] = 1'b1;
    return vec;
  endfunction

  assign accept        = in_valid && (state == IDLE);
  assign dwell_running = (cnt < DWELL_LAST);
  assign at_target     = (index == target);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (clr) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept && in_mode) state_nx = SWEEP;
        SWEEP:   if (!dwell_running && at_target) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Next values of the registered outputs and the sweep datapath.
  always_comb begin
    index_nx     = index;
    target_nx    = target;
    cnt_nx       = cnt;
    out_nx       = out;
    out_valid_nx = out_valid;
    done_nx      = 1'b0;
    if (clr) begin
      index_nx     = '0;
      cnt_nx       = '0;
      out_nx       = '0;
      out_valid_nx = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (in_mode) begin
              target_nx    = in_sel;
              index_nx     = '0;
              cnt_nx       = '0;
              out_nx       = onehot('0);
              out_valid_nx = 1'b0;
            end else begin
              out_nx       = onehot(in_sel);
              out_valid_nx = 1'b1;
            end
          end
        end
        SWEEP: begin
          if (dwell_running) begin
            cnt_nx = cnt + CNT_W'(1);
          end else if (!at_target) begin
            index_nx = index + SEL_W'(1);
            out_nx   = onehot(index + SEL_W'(1));
            cnt_nx   = '0;
          end else begin
            out_valid_nx = 1'b1;
            done_nx      = 1'b1;
          end
        end
        default: begin
          out_nx       = '0;
          out_valid_nx = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      index     <= '0;
      target    <= '0;
      cnt       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      index     <= index_nx;
      target    <= target_nx;
      cnt       <= cnt_nx;
      out       <= out_nx;
      out_valid <= out_valid_nx;
      done      <= done_nx;
    end
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state == SWEEP);

endmodule

// File: tb/tb_onehot_sweep_decoder.sv
// Bench for onehot_sweep_decoder: three configurations checked each cycle against a
// cycle-count reference model, plus directed scenarios and random traffic.
module tb_onehot_sweep_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] in_valid;
  logic [2:0] in_mode;
  logic [2:0] clr;
  logic [3:0] sel [3];

  logic       rdy0, rdy1, rdy2, ov0, ov1, ov2, bsy0, bsy1, bsy2, dn0, dn1, dn2;
  logic [7:0] out0, out1;
  logic [15:0] out2;

  onehot_sweep_decoder #(.SEL_W(3), .DWELL(2)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(rdy0), .in_sel(sel[0][2:0]),
    .in_mode(in_mode[0]), .clr(clr[0]), .out(out0), .out_valid(ov0), .busy(bsy0), .done(dn0));
  onehot_sweep_decoder #(.SEL_W(3), .DWELL(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(rdy1), .in_sel(sel[1][2:0]),
    .in_mode(in_mode[1]), .clr(clr[1]), .out(out1), .out_valid(ov1), .busy(bsy1), .done(dn1));
  onehot_sweep_decoder #(.SEL_W(4), .DWELL(3)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(rdy2), .in_sel(sel[2]),
    .in_mode(in_mode[2]), .clr(clr[2]), .out(out2), .out_valid(ov2), .busy(bsy2), .done(dn2));

  logic [15:0] g_out [3];
  logic [2:0]  g_rdy, g_ov, g_bsy, g_dn;
  always_comb begin
    g_out[0] = {8'h00, out0};
    g_out[1] = {8'h00, out1};
    g_out[2] = out2;
  end
  assign g_rdy = {rdy2, rdy1, rdy0};
  assign g_ov  = {ov2, ov1, ov0};
  assign g_bsy = {bsy2, bsy1, bsy0};
  assign g_dn  = {dn2, dn1, dn0};

  int sw [3] = '{3, 3, 4};
  int dw [3] = '{2, 1, 3};

  // Reference: a sweep accepted at cycle 0 shows position (n-1)/D in cycle n,
  // for n = 1..(T+1)D, and reports done in cycle (T+1)D+1.
  bit          m_sweep [3];
  int          m_n     [3];
  int          m_t     [3];
  logic [15:0] m_out   [3];
  bit          m_valid [3];
  bit          m_done  [3];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    int d;
    int s;
    for (int i = 0; i < 3; i++) begin
      d = dw[i];
      s = int'(sel[i]) & ((1 << sw[i]) - 1);
      if (rst || clr[i]) begin
        m_sweep[i] = 0; m_out[i] = '0; m_valid[i] = 0; m_done[i] = 0;
      end else begin
        m_done[i] = 0;
        if (!m_sweep[i] && in_valid[i]) begin
          if (in_mode[i]) begin
            m_sweep[i] = 1; m_n[i] = 1; m_t[i] = s; m_out[i] = 16'd1; m_valid[i] = 0;
          end else begin
            m_out[i] = 16'd1 << s; m_valid[i] = 1;
          end
        end else if (m_sweep[i]) begin
          m_n[i]++;
          if (m_n[i] > (m_t[i] + 1) * d) begin
            m_sweep[i] = 0; m_done[i] = 1; m_valid[i] = 1; m_out[i] = 16'd1 << m_t[i];
          end else begin
            m_out[i] = 16'd1 << ((m_n[i] - 1) / d);
          end
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("out[%0d]", i),   g_out[i], m_out[i]);
      chk($sformatf("valid[%0d]", i), g_ov[i],  m_valid[i]);
      chk($sformatf("busy[%0d]", i),  g_bsy[i], m_sweep[i]);
      chk($sformatf("done[%0d]", i),  g_dn[i],  m_done[i]);
      chk($sformatf("ready[%0d]", i), g_rdy[i], !m_sweep[i]);
      chk($sformatf("onehot0[%0d]", i), $onehot0(g_out[i]), 1'b1);
    end
  endtask

  task automatic wait_out0(input logic [15:0] val, input string tag);
    int k;
    k = 0;
    while (g_out[0] !== val && k < 40) begin
      cyc();
      k++;
    end
    chk(tag, g_out[0], val);
  endtask

  int busy_cnt;

  initial begin
    rst = 1'b1; in_valid = '0; in_mode = '0; clr = '0;
    for (int i = 0; i < 3; i++) begin
      sel[i] = '0; m_sweep[i] = 0; m_n[i] = 0; m_t[i] = 0;
      m_out[i] = '0; m_valid[i] = 0; m_done[i] = 0;
    end
    cyc(); cyc();
    rst = 1'b0;
    chk("reset_out", g_out[0], 16'h0);
    chk("reset_ready", g_rdy, 3'b111);

    in_valid[0] = 1; in_mode[0] = 0; sel[0] = 5;
    cyc();
    in_valid[0] = 0;
    chk("direct5_out", g_out[0], 16'h20);
    chk("direct5_valid", g_ov[0], 1'b1);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("rst_out", g_out[0], 16'h0);
    chk("rst_valid", g_ov[0], 1'b0);

    for (int k = 0; k < 8; k++) begin
      in_valid[0] = 1; in_mode[0] = 0; sel[0] = 4'(k);
      cyc();
      chk("b2b_out", g_out[0], 16'd1 << k);
      chk("b2b_ready", g_rdy[0], 1'b1);
    end
    in_valid[0] = 0;
    cyc();

    // DWELL=2 sweep to 3, with an ignored DIRECT command held during the sweep
    in_valid[0] = 1; in_mode[0] = 1; sel[0] = 3;
    cyc();
    in_mode[0] = 0; sel[0] = 7;
    for (int j = 0; j < 8; j++) begin
      chk("sweep3_out", g_out[0], 16'd1 << (j / 2));
      chk("sweep3_busy", g_bsy[0], 1'b1);
      cyc();
    end
    chk("sweep3_done", g_dn[0], 1'b1);
    chk("sweep3_final", g_out[0], 16'h08);
    chk("sweep3_valid", g_ov[0], 1'b1);
    in_valid[0] = 0;
    cyc();
    chk("sweep3_pulse", g_dn[0], 1'b0);

    // DWELL=1 sweep to 0, then DIRECT 7 accepted in the done cycle
    in_valid[1] = 1; in_mode[1] = 1; sel[1] = 0;
    cyc();
    in_valid[1] = 0;
    chk("sweep0_out", g_out[1], 16'h01);
    chk("sweep0_busy", g_bsy[1], 1'b1);
    cyc();
    chk("sweep0_done", g_dn[1], 1'b1);
    in_valid[1] = 1; in_mode[1] = 0; sel[1] = 7;
    cyc();
    in_valid[1] = 0;
    chk("b2b_direct7", g_out[1], 16'h80);

    // abort via clr, then via rst
    for (int a = 0; a < 2; a++) begin
      in_valid[0] = 1; in_mode[0] = 1; sel[0] = 6;
      cyc();
      in_valid[0] = 0;
      wait_out0(16'h04, "abort_reach4");
      if (a == 0) clr[0] = 1; else rst = 1;
      cyc();
      clr[0] = 0; rst = 0;
      chk("abort_out", g_out[0], 16'h0);
      chk("abort_valid", g_ov[0], 1'b0);
      chk("abort_busy", g_bsy[0], 1'b0);
      chk("abort_ready", g_rdy[0], 1'b1);
      for (int k = 0; k < 20; k++) begin
        cyc();
        chk("abort_nodone", g_dn[0], 1'b0);
      end
    end

    // SEL_W=4, DWELL=3 sweep to 15
    in_valid[2] = 1; in_mode[2] = 1; sel[2] = 15;
    cyc();
    in_valid[2] = 0;
    busy_cnt = 0;
    while (g_bsy[2] && busy_cnt < 100) begin
      busy_cnt++;
      cyc();
    end
    chk("sweep15_busy_cycles", busy_cnt, 48);
    chk("sweep15_out", g_out[2], 16'h8000);
    chk("sweep15_done", g_dn[2], 1'b1);

    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < 3; i++) begin
        clr[i]      = ($urandom_range(0, 39) == 0);
        in_valid[i] = $urandom_range(0, 1) == 1;
        in_mode[i]  = ($urandom_range(0, 2) == 0);
        sel[i]      = 4'($urandom_range(0, 15));
      end
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
